// File: rtl/jellyvl_etherneco_synctimer_scheduler_if.sv
// Control/monitor bundle between the CPU-side registers, the synctimer master
// and the sync scheduler. The scheduler connects through the slave modport.
interface jellyvl_etherneco_synctimer_scheduler_if #(
   parameter int PERIOD_WIDTH = 32,
   parameter int COUNT_WIDTH  = 16
);
   logic                    enable;
   logic [PERIOD_WIDTH-1:0] period;
   logic                    trigger;
   logic                    mon_valid;
   logic                    mon_ready;
   logic                    mon_last;
   logic                    rx_done;
   logic                    sync_start;
   logic                    sync_override;
   logic                    busy;
   logic [COUNT_WIDTH-1:0]  sync_count;
   logic [COUNT_WIDTH-1:0]  overrun_count;
   logic                    timeout_err;
   logic [COUNT_WIDTH-1:0]  latency;

   modport slave (
      input  enable, period, trigger, mon_valid, mon_ready, mon_last, rx_done,
      output sync_start, sync_override, busy, sync_count, overrun_count,
             timeout_err, latency
   );

   modport master (
      output enable, period, trigger, mon_valid, mon_ready, mon_last, rx_done,
      input  sync_start, sync_override, busy, sync_count, overrun_count,
             timeout_err, latency
   );
endinterface

// File: rtl/jellyvl_etherneco_synctimer_scheduler.sv
// EtherNeco synctimer scheduler: issues periodic/manual sync_start pulses,
// chooses override vs adjust-only syncs, tracks each sync frame from its last
// emitted beat to its return around the ring, and counts overruns/timeouts.
// Optional feature macro: ETHERNECO_SYNC_SCHED_LATENCY_EN (round-trip latency
// measurement); when undefined, latency is tied to 0.
module jellyvl_etherneco_synctimer_scheduler #(
   parameter int PERIOD_WIDTH   = 32,
   parameter int OVERRIDE_COUNT = 4,
   parameter int TIMEOUT        = 4096,
   parameter int COUNT_WIDTH    = 16
) (
   input  logic clk,
   input  logic reset,
   jellyvl_etherneco_synctimer_scheduler_if.slave s
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WAIT   = 3'd1,
      ST_START  = 3'd2,
      ST_SEND   = 3'd3,
      ST_RETURN = 3'd4
   } state_t;

   localparam int                     TMO_W   = $clog2(TIMEOUT + 1);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                  state_q, state_d;
   logic                    en_q;
   logic [PERIOD_WIDTH-1:0] per_q, per_d, reload;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [COUNT_WIDTH-1:0]  sync_count_q, sync_count_d;
   logic [COUNT_WIDTH-1:0]  overrun_q, overrun_d;
   logic                    terr_q, terr_d;
   logic                    tick, req, busy_w;

   // A period below 2 is clamped so the tick never fires every cycle.
   assign reload = (s.period < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1)
                                                 : s.period - PERIOD_WIDTH'(1);
   // The load cycle after enable rises never ticks (en_q is still 0 there).
   assign tick   = s.enable & en_q & (per_q == '0);
   assign req    = tick | s.trigger;
   assign busy_w = (state_q == ST_START) | (state_q == ST_SEND) | (state_q == ST_RETURN);

   // Period down-counter: reload on enable rise and on reaching 0, clear when off.
   always_comb begin
      per_d = per_q;
      if (!s.enable)
         per_d = '0;
      else if (!en_q || per_q == '0)
         per_d = reload;
      else
         per_d = per_q - PERIOD_WIDTH'(1);
   end

   // Next state plus the status counters that change with FSM transitions.
   always_comb begin
      state_d      = state_q;
      tmo_d        = tmo_q;
      sync_count_d = sync_count_q;
      terr_d       = terr_q;
      overrun_d    = overrun_q;
      // One request in a busy cycle is one overrun, even if tick and trigger coincide.
      if (busy_w && req && overrun_q != CNT_MAX)
         overrun_d = overrun_q + COUNT_WIDTH'(1);
      case (state_q)
         ST_IDLE: begin
            if (req)           state_d = ST_START;
            else if (s.enable) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (req)            state_d = ST_START;
            else if (!s.enable) state_d = ST_IDLE;
         end
         ST_START: state_d = ST_SEND;
         ST_SEND: begin
            if (s.mon_valid && s.mon_ready && s.mon_last) begin
               state_d = ST_RETURN;
               tmo_d   = '0;
            end
         end
         ST_RETURN: begin
            tmo_d = tmo_q + TMO_W'(1);
            // rx_done takes priority over a timeout in the same cycle.
            if (s.rx_done) begin
               if (sync_count_q != CNT_MAX)
                  sync_count_d = sync_count_q + COUNT_WIDTH'(1);
               state_d = s.enable ? ST_WAIT : ST_IDLE;
            end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
               terr_d       = 1'b1;
               sync_count_d = '0;   // lost sync: fall back to override syncs
               state_d      = s.enable ? ST_WAIT : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         en_q         <= 1'b0;
         per_q        <= '0;
         tmo_q        <= '0;
         sync_count_q <= '0;
         overrun_q    <= '0;
         terr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         en_q         <= s.enable;
         per_q        <= per_d;
         tmo_q        <= tmo_d;
         sync_count_q <= sync_count_d;
         overrun_q    <= overrun_d;
         terr_q       <= terr_d;
      end
   end

   assign s.sync_start    = (state_q == ST_START);
   assign s.sync_override = (state_q == ST_START) &&
                            (sync_count_q < COUNT_WIDTH'(OVERRIDE_COUNT));
   assign s.busy          = busy_w;
   assign s.sync_count    = sync_count_q;
   assign s.overrun_count = overrun_q;
   assign s.timeout_err   = terr_q;

`ifdef ETHERNECO_SYNC_SCHED_LATENCY_EN
   logic [COUNT_WIDTH-1:0] lat_cnt_q, lat_cnt_d, lat_q, lat_d;
   logic                   rx_ok;

   assign rx_ok = (state_q == ST_RETURN) & s.rx_done;

   // Cycle counter restarted by sync_start; captured on a successful return only.
   always_comb begin
      lat_cnt_d = lat_cnt_q;
      lat_d     = lat_q;
      if (state_q == ST_START)
         lat_cnt_d = COUNT_WIDTH'(1);
      else if (lat_cnt_q != CNT_MAX)
         lat_cnt_d = lat_cnt_q + COUNT_WIDTH'(1);
      if (rx_ok)
         lat_d = lat_cnt_q;
   end

   // Latency measurement registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt_q <= '0;
         lat_q     <= '0;
      end else begin
         lat_cnt_q <= lat_cnt_d;
         lat_q     <= lat_d;
      end
   end

   assign s.latency = lat_q;
`else
   assign s.latency = '0;
`endif

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_scheduler.sv
// Bench for the synctimer scheduler: directed scenarios with literal checks,
// plus a cycle-level reference model compared against the DUT every cycle.
module tb_jellyvl_etherneco_synctimer_scheduler;

   localparam int PW      = 32;
   localparam int CW      = 16;
   localparam int OVR     = 4;
   localparam int TMO     = 4096;
   localparam int SAT     = (1 << CW) - 1;
`ifdef ETHERNECO_SYNC_SCHED_LATENCY_EN
   localparam int LAT_EXP = 37;
`else
   localparam int LAT_EXP = 0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   int   tcyc = 0;
   int   n_starts = 0;

   jellyvl_etherneco_synctimer_scheduler_if #(.PERIOD_WIDTH(PW), .COUNT_WIDTH(CW)) sif ();

   jellyvl_etherneco_synctimer_scheduler #(
      .PERIOD_WIDTH(PW), .OVERRIDE_COUNT(OVR), .TIMEOUT(TMO), .COUNT_WIDTH(CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .s     (sif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) tcyc <= tcyc + 1;
   always @(negedge clk) if (sif.sync_start === 1'b1) n_starts <= n_starts + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         if (errors < 40) $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Works in absolute cycle numbers: ticks are scheduled one period apart,
   // a sync is "in flight" from its request until return or timeout.
   longint m_cyc = 0, m_next_tick = 0, m_last = 0, m_lat_start = 0;
   bit     m_en_prev = 0, m_start = 0, m_inflight = 0, m_sent = 0, m_terr = 0;
   int     m_cnt = 0, m_ovr = 0, m_lat = 0;

   always @(posedge clk or posedge reset) begin
      bit     tick, req;
      longint p;
      if (reset) begin
         m_en_prev = 0; m_start = 0; m_inflight = 0; m_sent = 0; m_terr = 0;
         m_cnt = 0; m_ovr = 0; m_lat = 0;
      end else begin
         p    = (sif.period < 2) ? 2 : longint'(sif.period);
         tick = 0;
         if (sif.enable) begin
            if (!m_en_prev) m_next_tick = m_cyc + p;
            else if (m_cyc == m_next_tick) begin
               tick        = 1;
               m_next_tick = m_cyc + p;
            end
         end
         m_en_prev = sif.enable;
         req = tick | sif.trigger;
         if (!m_inflight) begin
            if (req) begin
               m_start = 1; m_inflight = 1; m_sent = 0; m_lat_start = m_cyc + 1;
            end
         end else begin
            if (req && m_ovr < SAT) m_ovr++;
            if (m_start) m_start = 0;
            else if (!m_sent) begin
               if (sif.mon_valid && sif.mon_ready && sif.mon_last) begin
                  m_sent = 1; m_last = m_cyc;
               end
            end else if (sif.rx_done) begin
               if (m_cnt < SAT) m_cnt++;
`ifdef ETHERNECO_SYNC_SCHED_LATENCY_EN
               m_lat = (m_cyc - m_lat_start > SAT) ? SAT : int'(m_cyc - m_lat_start);
`endif
               m_inflight = 0;
            end else if (m_cyc - m_last == TMO) begin
               m_terr = 1; m_cnt = 0; m_inflight = 0;
            end
         end
         m_cyc++;
      end
   end

   // Compare every cycle, mid-cycle on the falling edge.
   always @(negedge clk) begin
      chk("sync_start",    sif.sync_start,    m_start);
      chk("sync_override", sif.sync_override, m_start && (m_cnt < OVR));
      chk("busy",          sif.busy,          m_inflight);
      chk("sync_count",    sif.sync_count,    m_cnt);
      chk("overrun_count", sif.overrun_count, m_ovr);
      chk("timeout_err",   sif.timeout_err,   m_terr);
      chk("latency",       sif.latency,       m_lat);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   // Waits for sync_start, sends a frame of `beats` beats (last on the final
   // one), then pulses rx_done `gap` cycles after the last beat.
   task automatic run_frame(input int beats, input int gap, input bit give_rx,
                            input int trig_beat, input int drop_beat,
                            output bit ovr, output int s_cyc, output int l_cyc);
      int n = 0;
      while (sif.sync_start !== 1'b1 && n < 1000) begin step(); n++; end
      if (n >= 1000) begin
         errors++;
         $display("FAIL wait_sync_start actual=none expected=pulse within 1000 cycles");
      end
      ovr   = sif.sync_override;
      s_cyc = tcyc;
      for (int b = 1; b <= beats; b++) begin
         step();
         sif.mon_valid = 1; sif.mon_ready = 1; sif.mon_last = (b == beats);
         sif.trigger   = (b == trig_beat);
         if (b == drop_beat) sif.enable = 0;
      end
      l_cyc = tcyc;
      step();
      sif.mon_valid = 0; sif.mon_ready = 0; sif.mon_last = 0; sif.trigger = 0;
      if (give_rx) begin
         repeat (gap - 1) @(posedge clk);
         #1 sif.rx_done = 1;
         step();
         sif.rx_done = 0;
      end
   endtask

   initial begin
      bit ov[6];
      int sc[6];
      bit o;
      int s, l, e, n0, n;
      reset = 1;
      sif.enable = 0; sif.period = 100; sif.trigger = 0;
      sif.mon_valid = 0; sif.mon_ready = 0; sif.mon_last = 0; sif.rx_done = 0;
      #22;
      chk("rst_sync_start", sif.sync_start, 0);
      chk("rst_busy",       sif.busy, 0);
      chk("rst_sync_count", sif.sync_count, 0);
      chk("rst_overrun",    sif.overrun_count, 0);
      chk("rst_timeout",    sif.timeout_err, 0);
      chk("rst_latency",    sif.latency, 0);
      reset = 0;
      step();

      // periodic syncs, period 100; first four carry override
      sif.enable = 1; e = tcyc;
      for (int i = 0; i < 6; i++) run_frame(12, 20, 1, 0, 0, ov[i], sc[i], l);
      for (int i = 0; i < 6; i++) chk($sformatf("override_sync%0d", i + 1), ov[i], (i < 4) ? 1 : 0);
      chk("first_start_cycle", sc[0] - e, 101);
      chk("spacing_1_2", sc[1] - sc[0], 100);
      chk("spacing_2_3", sc[2] - sc[1], 100);

      // trigger during SEND is dropped as an overrun
      run_frame(12, 20, 1, 3, 0, o, s, l);
      chk("overrun_after_send_trig", sif.overrun_count, 1);
      chk("starts_after_overrun", n_starts, 7);

      // tick and trigger in the same WAIT cycle: one sync only, no overrun
      sif.enable = 0; step(); step(); step();
      sif.enable = 1; e = tcyc; n0 = n_starts;
      repeat (100) @(posedge clk);
      #1 sif.trigger = 1;
      step();
      sif.trigger = 0;
      chk("tick_trig_start_now", sif.sync_start, 1);
      run_frame(12, 20, 1, 0, 0, o, s, l);
      chk("tick_trig_one_start", n_starts - n0, 1);
      chk("tick_trig_no_overrun", sif.overrun_count, 1);

      // rx_done withheld -> timeout; flag visible the cycle after the
      // 4096th cycle following the last beat
      sif.enable = 0; sif.trigger = 1; step(); sif.trigger = 0;
      run_frame(12, 0, 0, 0, 0, o, s, l);
      n = 0;
      while (sif.timeout_err !== 1'b1 && n < 5000) begin step(); n++; end
      chk("timeout_delay", tcyc - l, TMO + 1);
      chk("timeout_err", sif.timeout_err, 1);
      chk("timeout_count_cleared", sif.sync_count, 0);
      sif.trigger = 1; step(); sif.trigger = 0;
      run_frame(12, 20, 1, 0, 0, o, s, l);
      chk("override_after_timeout", o, 1);

      // enable dropped mid-frame: frame completes, then nothing more
      sif.enable = 1; n0 = n_starts;
      run_frame(12, 20, 1, 0, 5, o, s, l);
      chk("drop_en_idle", sif.busy, 0);
      chk("drop_en_count", sif.sync_count, 2);
      repeat (300) @(posedge clk);
      #1 chk("drop_en_no_more_starts", n_starts - n0, 1);

      // latency: rx_done 37 cycles after sync_start
      sif.trigger = 1; step(); sif.trigger = 0;
      run_frame(12, 25, 1, 0, 0, o, s, l);
      chk("latency_37", sif.latency, LAT_EXP);

      // async reset in the middle of RETURN
      sif.trigger = 1; step(); sif.trigger = 0;
      run_frame(12, 0, 0, 0, 0, o, s, l);
      repeat (5) @(posedge clk);
      #2 reset = 1;
      #1;
      chk("arst_busy",       sif.busy, 0);
      chk("arst_sync_count", sif.sync_count, 0);
      chk("arst_overrun",    sif.overrun_count, 0);
      chk("arst_timeout",    sif.timeout_err, 0);
      chk("arst_latency",    sif.latency, 0);
      chk("arst_sync_start", sif.sync_start, 0);
      #3 reset = 0;
      step();
      sif.trigger = 1; step(); sif.trigger = 0;
      run_frame(12, 20, 1, 0, 0, o, s, l);
      chk("override_after_reset", o, 1);
      chk("count_after_reset", sif.sync_count, 1);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
